arm_mc_ctrl: RTL
================

Name: arm_mc_ctrl

Overview:
Multicycle control unit for the ARMv4-subset core. It replaces the single-cycle controller and sequences a shared datapath in which one memory serves instruction fetch and data access, and the single ALU also computes PC+4. It contains the main FSM, the ALU decoder, the condition check and the NZCV flag register. It drives every mux select and write enable of the multicycle datapath.

Parameters:
FLAGS_RST, 4'b0000, reset value of the {N,Z,C,V} flag register
DP_ILLEGAL_NOP, 1, 1: unimplemented cmd executes as a NOP with an illegal pulse; 0: ALUControl is x for unimplemented cmd (simulation only)

Ports:
clk  in  1  clock
reset  in  1  reset
Instr  in  20  IR[31:12] (cond, op, funct, Rn, Rd), driven from the datapath instruction register
ALUFlags  in  4  {N,Z,C,V} from the ALU, combinational
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register enable
ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  1  SrcA select: 0=RD1, 1=PC
ALUSrcB  out  2  SrcB select: 00=RD2, 01=ExtImm, 10=constant 4
ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
ImmSrc  out  2  extend mode; equals Instr[27:26]
RegSrc  out  2  register-address selects, same encoding as single-cycle
RegWrite  out  1  register file write enable
Flags  out  4  current flag register contents
illegal  out  1  one-cycle pulse on an unimplemented instruction

Behaviour:
- Reset: asynchronous, active-high. Reset is the only asynchronous event. State goes to FETCH and Flags to FLAGS_RST. While reset is high, all write enables (PCWrite, MemWrite, IRWrite, RegWrite, flag write) and illegal are forced to 0. Reset mid-instruction abandons the instruction; no partial writes follow.
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10; this forms PC+8 for R15 reads.
  - op=01 → MEMADR.
  - op=00 with I=1 → EXECI; op=00 with I=0 → EXECR.
  - op=10 → BRANCH.
  - op=11 → FETCH, with illegal=1.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. L=1 → MEMRD; L=0 → MEMWR.
- MEMRD: AdrSrc=1. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. If Rd=15, PCWrite=CondEx. Next state FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx. Next state FETCH.
- EXECR / EXECI: ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI); ALUControl from cmd.
  - If S=1 and CondEx: N,Z are loaded at the clock edge ending this state.
  - C,V are loaded only for ADD, SUB and CMP.
  - Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite. If Rd=15 and ~NoWrite, PCWrite=CondEx. Next state FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. Next state FETCH.
- CondEx is evaluated from the registered Flags (not ALUFlags), using the standard 16-entry cond table. cond=1111 gives CondEx=0.
- Flags written in EXEC become visible to the next instruction's CondEx, never to the current one.
- Latency: DP=4 cycles, LDR=5, STR=4, B=3, illegal=2.
- Unimplemented cmd with DP_ILLEGAL_NOP=1: illegal pulses in EXEC; no register or flag writes occur.
- A failed condition still consumes the full cycle count; only PC+4 is committed.

Optional Feature:
- Macro: ARM_CMP_TST_EN.
- Defined:
  - cmd 1010 (CMP) decodes as SUB with NoWrite=1.
  - cmd 1000 (TST) decodes as AND with NoWrite=1.
  - For both, flags are written regardless of the S bit; no register write occurs.
- Undefined: both cmds are unimplemented and handled per DP_ILLEGAL_NOP.

Decomposition:
- Package arm_mc_pkg holds:
  - state_t enum;
  - ALUControl codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR);
  - cmd constants (CMD_ADD=0100, CMD_SUB=0010, CMD_AND=0000, CMD_ORR=1100, CMD_CMP=1010, CMD_TST=1000);
  - ResultSrc, ALUSrcB and op encodings.
- Sub-module arm_mc_condunit holds the flag register, the condcheck table and the write gating.
- The FSM and ALU decoder stay in arm_mc_ctrl.

Test Plan:
- Reset: reset high mid-MEMWR, Flags=1111 → MemWrite=0 immediately; after release, state=FETCH, Flags=FLAGS_RST, first cycle IRWrite=PCWrite=1.
- ADDS R1,R0,#0 (R0=0, cond=1110) → states FETCH, DECODE, EXECI, ALUWB; Flags=0100 after EXECI; RegWrite=1 only in ALUWB.
- LDR (cond=1110), then STR with cond=0001 while Z=1 → LDR: RegWrite pulse in 5th cycle; STR: 4 cycles with MemWrite=0 throughout.
- B with cond=0000 and Z=1 → PCWrite=1 in BRANCH, ResultSrc=10; repeat with Z=0 → PCWrite=0 in BRANCH.
- CMP R0,#5 (R0=5) with ARM_CMP_TST_EN → Flags=0110, RegWrite=0 in ALUWB; without the macro → illegal pulse, Flags unchanged.
- ADD R15,R0,#0 (Rd=15) → PCWrite=1 and RegWrite=1 in ALUWB; instruction word 0xEC000000 (op=11) → illegal=1 in DECODE, back in FETCH next cycle.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Purpose: shared types and encodings for the multicycle ARM control unit:
//   FSM state enum, ALU/cmd/op/mux-select codes, the registered control word
//   and the 16-entry condition table.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_TST = 4'b1000;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // Control word held in registers for the state currently being executed.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic       reg_write;
    logic [1:0] flag_w;      // {load N/Z, load C/V}
    logic       illegal;
  } ctl_t;

  localparam ctl_t CTL_FETCH = '{
    pc_write: 1'b1, adr_src: 1'b0, mem_write: 1'b0, ir_write: 1'b1,
    result_src: RES_ALURESULT, alu_src_a: 1'b1, alu_src_b: SRCB_FOUR,
    alu_control: ALU_ADD, reg_write: 1'b0, flag_w: 2'b00, illegal: 1'b0
  };

  // Standard ARM condition table; 1111 never executes in this core.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: cond_check = z;
      4'b0001: cond_check = ~z;
      4'b0010: cond_check = c;
      4'b0011: cond_check = ~c;
      4'b0100: cond_check = n;
      4'b0101: cond_check = ~n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = ~v;
      4'b1000: cond_check = c & ~z;
      4'b1001: cond_check = ~c | z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = ~z & (n == v);
      4'b1101: cond_check = z | (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_ctrl_if.sv
// Purpose: control/status bundle between the multicycle controller (master)
//   and the shared datapath (slave). Instr/ALUFlags flow to the controller,
//   every mux select, write enable, Flags and illegal flow to the datapath.
// Latency: n/a (wires only). Backpressure: none; the datapath always obeys.
interface arm_mc_ctrl_if;
  logic [19:0] Instr;       // IR[31:12]: cond, op, funct, Rn, Rd
  logic [3:0]  ALUFlags;    // {N,Z,C,V} from the ALU
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [3:0]  Flags;
  logic        illegal;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, Flags, illegal
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, Flags, illegal
  );
endinterface

// File: rtl/arm_mc_condunit.sv
// Purpose: NZCV flag register, condition check and flag write gating.
// Latency: CondEx is combinational from the registered flags; flag loads land
//   at the clock edge. Backpressure: none.
// Ports: clk, reset (async, active-high); cond_i instruction condition;
//   alu_flags_i ALU {N,Z,C,V}; flag_w_i {NZ,CV} load requests (ungated);
//   cond_ex_o condition result; flags_o current flag register.
module arm_mc_condunit
  import arm_mc_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  output logic       cond_ex_o,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q, flags_d;
  logic [1:0] flag_we;

  // Evaluated from the stored flags, so a flag load in EXEC cannot change the
  // outcome for the instruction that produced it.
  assign cond_ex_o = cond_check(cond_i, flags_q);
  assign flag_we   = flag_w_i & {2{cond_ex_o}};

  always_comb begin
    flags_d = flags_q;
    if (flag_we[1]) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_we[0]) flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= FLAGS_RST;
    else       flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/arm_mc_ctrl.sv
// Purpose: multicycle control unit (main FSM + ALU decoder) for the ARMv4-subset
//   core; drives every select/enable of the shared datapath through bus.
// Latency: DP 4, LDR 5, STR 4, B 3, undefined op 2 cycles. Backpressure: none.
// Ports: clk, reset (async, active-high), bus (arm_mc_ctrl_if.master).
// Build option: define ARM_CMP_TST_EN to implement CMP and TST.
module arm_mc_ctrl
  import arm_mc_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST      = 4'b0000,
  parameter bit         DP_ILLEGAL_NOP = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  arm_mc_ctrl_if.master bus
);

  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       i_bit, s_bit;
  logic       cond_ex;
  logic [3:0] flags;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign i_bit     = bus.Instr[13];
  assign cmd       = bus.Instr[12:9];
  assign s_bit     = bus.Instr[8];   // also L for memory instructions
  assign rd        = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];

  // ALU decoder
  logic [1:0] dec_alu;
  logic       dec_impl, dec_nowrite, dec_force_s, dec_cv;

  always_comb begin
    dec_alu     = ALU_ADD;
    dec_impl    = 1'b1;
    dec_nowrite = 1'b0;
    dec_force_s = 1'b0;
    dec_cv      = 1'b0;
    case (cmd)
      CMD_ADD: begin dec_alu = ALU_ADD; dec_cv = 1'b1; end
      CMD_SUB: begin dec_alu = ALU_SUB; dec_cv = 1'b1; end
      CMD_AND: dec_alu = ALU_AND;
      CMD_ORR: dec_alu = ALU_ORR;
`ifdef ARM_CMP_TST_EN
      CMD_CMP: begin
        dec_alu = ALU_SUB; dec_nowrite = 1'b1; dec_force_s = 1'b1; dec_cv = 1'b1;
      end
      CMD_TST: begin
        dec_alu = ALU_AND; dec_nowrite = 1'b1; dec_force_s = 1'b1;
      end
`endif
      default: begin
        // Unimplemented cmd never writes registers or flags; with the NOP
        // option off the ALU operation is left as don't-care.
        dec_impl = 1'b0;
        dec_alu  = DP_ILLEGAL_NOP ? ALU_ADD : 2'bxx;
      end
    endcase
  end

  // Next state, then the control word for that next state. Everything that
  // depends on CondEx is sampled here, one cycle ahead, so ALUWB sees the
  // condition as it stood before its own EXEC flag load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_DP:   state_d = i_bit ? EXECI : EXECR;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = s_bit ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECR,
      EXECI:   state_d = ALUWB;
      default: state_d = FETCH;    // MEMWB, MEMWR, ALUWB, BRANCH
    endcase

    ctl_d = '0;
    case (state_d)
      FETCH:  ctl_d = CTL_FETCH;
      DECODE: begin
        ctl_d.alu_src_a  = 1'b1;
        ctl_d.alu_src_b  = SRCB_FOUR;
        ctl_d.result_src = RES_ALURESULT;
      end
      MEMADR: ctl_d.alu_src_b = SRCB_EXTIMM;
      MEMRD:  ctl_d.adr_src = 1'b1;
      MEMWB: begin
        ctl_d.result_src = RES_DATA;
        ctl_d.reg_write  = cond_ex;
        ctl_d.pc_write   = cond_ex & (rd == 4'd15);
      end
      MEMWR: begin
        ctl_d.adr_src   = 1'b1;
        ctl_d.mem_write = cond_ex;
      end
      EXECR, EXECI: begin
        ctl_d.alu_src_b   = (state_d == EXECI) ? SRCB_EXTIMM : SRCB_RD2;
        ctl_d.alu_control = dec_alu;
        ctl_d.flag_w[1]   = dec_impl & (s_bit | dec_force_s);
        ctl_d.flag_w[0]   = dec_impl & (s_bit | dec_force_s) & dec_cv;
        ctl_d.illegal     = ~dec_impl & DP_ILLEGAL_NOP;
      end
      ALUWB: begin
        ctl_d.result_src = RES_ALUOUT;
        ctl_d.reg_write  = cond_ex & dec_impl & ~dec_nowrite;
        ctl_d.pc_write   = cond_ex & dec_impl & ~dec_nowrite & (rd == 4'd15);
      end
      BRANCH: begin
        ctl_d.alu_src_b  = SRCB_EXTIMM;
        ctl_d.result_src = RES_ALURESULT;
        ctl_d.pc_write   = cond_ex;
      end
      default: ctl_d = '0;
    endcase
  end

  // Reset loads the FETCH control word so the first cycle after release
  // fetches; the enables are masked by reset below while it is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctl_q   <= CTL_FETCH;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  arm_mc_condunit #(.FLAGS_RST(FLAGS_RST)) u_condunit (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (cond),
    .alu_flags_i (bus.ALUFlags),
    .flag_w_i    (ctl_q.flag_w & {2{~reset}}),
    .cond_ex_o   (cond_ex),
    .flags_o     (flags)
  );

  assign bus.PCWrite    = ctl_q.pc_write  & ~reset;
  assign bus.MemWrite   = ctl_q.mem_write & ~reset;
  assign bus.IRWrite    = ctl_q.ir_write  & ~reset;
  assign bus.RegWrite   = ctl_q.reg_write & ~reset;
  assign bus.AdrSrc     = ctl_q.adr_src;
  assign bus.ResultSrc  = ctl_q.result_src;
  assign bus.ALUSrcA    = ctl_q.alu_src_a;
  assign bus.ALUSrcB    = ctl_q.alu_src_b;
  assign bus.ALUControl = ctl_q.alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
  assign bus.Flags      = flags;
  // The IR only holds the new instruction from DECODE onward, so the
  // undefined-op pulse is decoded from the live state rather than preloaded.
  assign bus.illegal    = ~reset & (ctl_q.illegal | ((state_q == DECODE) && (op == OP_UNDEF)));

endmodule
